// File: rtl/mem_access_stage.sv
// mem_access_stage
// Memory stage of the 5-stage RISC-V pipeline. Takes the EX/MEM register,
// drives a req/ready data-memory port (alignment check, store lane steering,
// load extraction and sign/zero extension), resolves branches, stalls the
// upstream stages while memory is busy, and registers the MEM/WB outputs.
//
// Ports:
//   clk, reset                 clock (rising edge), async active-high reset
//   Ctl_*_in, Zero_in, Rd_in   EX/MEM control bits, zero flag, destination
//   funct3_in                  [1:0] size (00 b, 01 h, 10 w, 11 illegal), [2] unsigned load
//   ALUresult_in               effective address / ALU result
//   ReadData2_in, PCimm_in     store data, branch target
//   PCSrc_out, PCimm_out       combinational branch resolution
//   stall_out                  combinational freeze of PC, IF/ID, ID/EX, EX/MEM
//   dmem_*                     data-memory request port
//   Ctl_*_out, Rd_out, ALUresult_out, ReadData_out   MEM/WB register
//   misalign_out, bus_err_out  one-cycle exception flags in MEM/WB
module mem_access_stage #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Ctl_MemtoReg_in,
    input  logic        Ctl_RegWrite_in,
    input  logic        Ctl_MemRead_in,
    input  logic        Ctl_MemWrite_in,
    input  logic        Ctl_Branch_in,
    input  logic        Zero_in,
    input  logic [4:0]  Rd_in,
    input  logic [2:0]  funct3_in,
    input  logic [31:0] ALUresult_in,
    input  logic [31:0] ReadData2_in,
    input  logic [31:0] PCimm_in,
    output logic        PCSrc_out,
    output logic [31:0] PCimm_out,
    output logic        stall_out,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        Ctl_MemtoReg_out,
    output logic        Ctl_RegWrite_out,
    output logic [4:0]  Rd_out,
    output logic [31:0] ALUresult_out,
    output logic [31:0] ReadData_out,
    output logic        misalign_out,
    output logic        bus_err_out
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;
    localparam logic [7:0] TIMEOUT = 8'(TIMEOUT_CYCLES);

    logic [0:0]  state;
    logic [7:0]  cnt;
    logic        access;
    logic        aligned;
    logic        timeout;
    logic [1:0]  off;
    logic [31:0] shifted;
    logic [31:0] load_data;

    assign PCSrc_out = Ctl_Branch_in & Zero_in;
    assign PCimm_out = PCimm_in;

    assign off       = ALUresult_in[1:0];
    assign access    = Ctl_MemRead_in | Ctl_MemWrite_in;
    assign dmem_addr = {ALUresult_in[31:2], 2'b00};

    always_comb begin
        case (funct3_in[1:0])
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = ~off[0];
            2'b10:   aligned = (off == 2'b00);
            default: aligned = 1'b0;
        endcase
    end

    // Last WAIT cycle without ready: release the pipeline and retire a bubble.
    assign timeout = (state == S_WAIT) & ~dmem_ready & (cnt == TIMEOUT);

    // Reset gates the request path directly so req/stall drop at once, even mid-WAIT.
    assign dmem_req  = ~reset & ((state == S_WAIT) | (access & aligned));
    assign dmem_we   = dmem_req & Ctl_MemWrite_in & ~Ctl_MemRead_in;
    assign stall_out = dmem_req & ~dmem_ready & ~timeout;

    always_comb begin
        dmem_wdata = ReadData2_in;
        dmem_be    = 4'b1111;
        if (Ctl_MemWrite_in && !Ctl_MemRead_in) begin
            case (funct3_in[1:0])
                2'b00: begin
                    dmem_wdata = {4{ReadData2_in[7:0]}};
                    dmem_be    = 4'b0001 << off;
                end
                2'b01: begin
                    dmem_wdata = {2{ReadData2_in[15:0]}};
                    dmem_be    = 4'b0011 << off;
                end
                default: begin
                    dmem_wdata = ReadData2_in;
                    dmem_be    = 4'b1111;
                end
            endcase
        end
    end

    assign shifted = dmem_rdata >> {off, 3'b000};

    always_comb begin
        case (funct3_in[1:0])
            2'b00:   load_data = funct3_in[2] ? {24'b0, shifted[7:0]}
                                              : {{24{shifted[7]}}, shifted[7:0]};
            2'b01:   load_data = funct3_in[2] ? {16'b0, shifted[15:0]}
                                              : {{16{shifted[15]}}, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    // Request/wait FSM with cycle counter for the bus timeout.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= 8'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (access && aligned && !dmem_ready) begin
                        state <= S_WAIT;
                        cnt   <= 8'd1;
                    end
                end
                default: begin
                    if (dmem_ready || timeout) begin
                        state <= S_IDLE;
                        cnt   <= 8'd0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
            endcase
        end
    end

    // MEM/WB register: bubble while stalled, exception bubbles for
    // misaligned or timed-out accesses, otherwise the instruction itself.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Ctl_MemtoReg_out <= 1'b0;
            Ctl_RegWrite_out <= 1'b0;
            Rd_out           <= 5'd0;
            ALUresult_out    <= 32'd0;
            ReadData_out     <= 32'd0;
            misalign_out     <= 1'b0;
            bus_err_out      <= 1'b0;
        end else begin
            Ctl_MemtoReg_out <= 1'b0;
            Ctl_RegWrite_out <= 1'b0;
            Rd_out           <= 5'd0;
            ALUresult_out    <= 32'd0;
            ReadData_out     <= 32'd0;
            misalign_out     <= 1'b0;
            bus_err_out      <= 1'b0;
            if (!stall_out) begin
                if (access && !aligned) begin
                    misalign_out <= 1'b1;
                end else if (timeout) begin
                    bus_err_out <= 1'b1;
                end else begin
                    Ctl_MemtoReg_out <= Ctl_MemtoReg_in;
                    Ctl_RegWrite_out <= Ctl_RegWrite_in;
                    Rd_out           <= Rd_in;
                    ALUresult_out    <= ALUresult_in;
                    ReadData_out     <= Ctl_MemRead_in ? load_data : 32'd0;
                end
            end
        end
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory stage of the 5-stage RISC-V pipeline; consumes the EX/MEM register produced by the execute stage (ALU result, store data, PC+imm, Zero, control bits).
- Drives a req/ready data-memory port and performs byte/half/word alignment, store lane steering and load sign-extension.
- Resolves branches and stalls upstream stages while memory is busy.
- Registers the MEM/WB pipeline outputs.

Parameters:
- TIMEOUT_CYCLES, 255, maximum cycles in WAIT before the access is abandoned (range 1..255, 8-bit counter).

Ports:
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-high reset
- Ctl_MemtoReg_in, Ctl_RegWrite_in, Ctl_MemRead_in, Ctl_MemWrite_in, Ctl_Branch_in  in  1 each  EX/MEM control bits
- Zero_in  in  1  ALU zero flag from EX/MEM
- Rd_in  in  5  destination register
- funct3_in  in  3  access size/sign: [1:0] 00=byte 01=half 10=word 11=illegal; [2]=unsigned load
- ALUresult_in  in  32  effective address / ALU result
- ReadData2_in  in  32  store data
- PCimm_in  in  32  branch target
- PCSrc_out  out  1  combinational, Ctl_Branch_in & Zero_in
- PCimm_out  out  32  combinational passthrough of PCimm_in
- stall_out  out  1  combinational; freezes PC, IF/ID, ID/EX, EX/MEM
- dmem_req, dmem_we  out  1 each  memory request / write enable
- dmem_addr  out  32  {ALUresult_in[31:2],2'b00}
- dmem_wdata  out  32  lane-steered store data
- dmem_be  out  4  byte enables
- dmem_ready  in  1  access complete this cycle (rdata valid for reads)
- dmem_rdata  in  32  read word
- Ctl_MemtoReg_out, Ctl_RegWrite_out  out  1 each  MEM/WB control
- Rd_out  out  5  MEM/WB destination
- ALUresult_out, ReadData_out  out  32 each  MEM/WB ALU result, aligned load data
- misalign_out, bus_err_out  out  1 each  one-cycle MEM/WB exception flags

Behaviour:
- Reset (async, immediate): state=IDLE, counter=0, all registered outputs 0. dmem_req drops the same instant, including mid-WAIT.
- access = MemRead_in | MemWrite_in. If both are set, the read wins and dmem_we=0.
- Misaligned when funct3[1:0]=11, or half with addr[0]=1, or word with addr[1:0]!=0.
- Misaligned access: no dmem_req and no stall. MEM/WB loads RegWrite=0, MemtoReg=0, Rd=0, misalign_out=1 for one cycle.
- Store steering:
  - byte: wdata={4{d[7:0]}}, be=4'b0001<<addr[1:0]
  - half: wdata={2{d[15:0]}}, be=4'b0011<<addr[1:0]
  - word: wdata=d, be=4'b1111
- dmem_be=4'b1111 for reads.
- Load: shift dmem_rdata right by 8*addr[1:0], then extend the byte/half to 32 bits, sign-extended if funct3[2]=0, zero-extended if funct3[2]=1.
- FSM IDLE:
  - dmem_req = access & aligned.
  - If the request is made and dmem_ready=1 in the same cycle: single-cycle completion, stall_out=0, MEM/WB captures the result.
  - If the request is made and dmem_ready=0: stall_out=1, go to WAIT, counter=1.
- FSM WAIT:
  - dmem_req=1; addr/we/wdata/be stay stable because EX/MEM is frozen.
  - stall_out = ~dmem_ready.
  - On dmem_ready: capture, go to IDLE, counter=0.
  - If counter==TIMEOUT_CYCLES with no ready: drop req next cycle, stall_out=0 in the final cycle, MEM/WB gets a bubble with bus_err_out=1, go to IDLE.
  - Otherwise counter+1.
- MEM/WB register:
  - When stall_out=1, loads a bubble (RegWrite=0, MemtoReg=0, Rd=0, flags 0).
  - Otherwise loads the instruction: ALUresult_out=ALUresult_in, ReadData_out=aligned load data (0 for non-loads).
- Non-memory instructions: pass through in one cycle, never stall.
- PCSrc_out/PCimm_out are independent of the FSM.

Test Plan:
- Reset during WAIT (req high, ready low) → dmem_req, stall_out and all MEM/WB outputs go to 0 immediately; state is IDLE after reset release.
- lw at addr 0x100, dmem_ready=1 same cycle, rdata=0xDEADBEEF, Rd=5 → no stall; next edge: ReadData_out=0xDEADBEEF, RegWrite=1, MemtoReg=1, Rd_out=5.
- lb at 0x103, rdata=0x80112233, ready after 3 cycles → stall_out high for 3 cycles with bubbles in MEM/WB; then ReadData_out=0xFFFFFF80. Same access as lbu → 0x00000080.
- sh at 0x202, data 0x0000ABCD → dmem_addr=0x200, wdata=0xABCDABCD, be=4'b1100, we=1. sh at 0x201 → no req, misalign_out=1, RegWrite_out=0.
- TIMEOUT_CYCLES=4, lw with ready held 0 → stall for 4 cycles, then bus_err_out=1 for one cycle, req drops, next instruction proceeds.
- Branch_in=1, Zero_in=1, PCimm_in=0x40 → PCSrc_out=1, PCimm_out=0x40 combinationally. Zero_in=0 → PCSrc_out=0; no dmem_req in either case.
